obstacle_manager: RTL



---
 rtl/obstacle_pkg.sv | 53 +++++
 rtl/obstacle_manager_lfsr16.sv | 22 ++
 rtl/obstacle_manager.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle table: word layout, table depth, screen size, burst states.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package obstacle_pkg;

    // Table geometry, shared with the track renderer
    localparam int NUM_OBSTACLES = 10;
    localparam int SCREEN_WIDTH  = 1024;
    localparam int SCREEN_HEIGHT = 768;

    // Obstacle word layout: {type[14:13], pos[12:3], lane[2:1], active[0]}
    localparam int OBS_W      = 15;
    localparam int TYPE_MSB   = 14;
    localparam int TYPE_LSB   = 13;
    localparam int POS_MSB    = 12;
    localparam int POS_LSB    = 3;
    localparam int LANE_MSB   = 2;
    localparam int LANE_LSB   = 1;
    localparam int ACTIVE_BIT = 0;

    localparam int POS_W = POS_MSB - POS_LSB + 1;
    localparam int IDX_W = $clog2(NUM_OBSTACLES);

    // Per-frame update burst
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        SPAWN  = 2'd2
    } state_t;

    // Lane comes from the two LSBs; the unused code 3 is folded onto lane 0/1 using bit 2
    function automatic logic [1:0] lane_from_lfsr(input logic [2:0] l);
        logic [1:0] lane;
        lane = l[1:0];
        if (l[1:0] == 2'd3) begin
            lane = {1'b0, l[2]};
        end
        return lane;
    endfunction

    // Fresh obstacle word at the spawn column, lane/type drawn from the LFSR state
    function automatic logic [OBS_W-1:0] make_spawn_word(input logic [4:0]       l,
                                                         input logic [POS_W-1:0] x);
        logic [OBS_W-1:0] w;
        w                      = '0;
        w[TYPE_MSB:TYPE_LSB]   = l[4:3];
        w[POS_MSB:POS_LSB]     = x;
        w[LANE_MSB:LANE_LSB]   = lane_from_lfsr(l[2:0]);
        w[ACTIVE_BIT]          = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/obstacle_manager_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 15,13,12,10), shifting left, advanced only on step.
// Latency: new state visible the cycle after step.
// Backpressure: none; step is a single-cycle enable.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    output logic [15:0] q
);

    // Shift register with synchronous reload of the seed
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= SEED;
        end else if (step) begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/obstacle_manager.sv
// Owns the obstacle table: per-frame scroll/retire of every slot, then a gap-limited LFSR spawn.
// Latency: burst starts the edge after the vsync rise is seen; table final 12 cycles later, busy 11 cycles.
// Backpressure: none; vsync rises while busy (or with run low) are dropped, never queued.
module obstacle_manager
    import obstacle_pkg::*;
#(
    parameter int              SPAWN_GAP = 60,
    parameter logic [9:0]      SPAWN_X   = 10'd1023,
    parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
    input  logic                                 system_clock_in,
    input  logic                                 system_reset_n_in,
    input  logic                                 vsync,
    input  logic                                 run,
    input  logic                                 clear,
    input  logic [3:0]                           speed,
    output logic [NUM_OBSTACLES-1:0][OBS_W-1:0]  obstacles,
    output logic                                 busy,
    output logic                                 spawn_pulse
);

    localparam int                GAP_W    = $clog2(SPAWN_GAP + 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(SPAWN_GAP);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_OBSTACLES - 1);

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [3:0]           speed_q;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 vsync_q;
    logic                 frame_tick;
    logic                 accept;
    logic                 lfsr_step;
    logic [15:0]          lfsr_q;

    logic [OBS_W-1:0]     cur_word;
    logic [POS_W-1:0]     cur_pos;
    logic [POS_W-1:0]     speed_ext;
    logic [OBS_W-1:0]     scroll_word;
    logic [OBS_W-1:0]     spawn_word;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 spawn_go;
    logic                 last_slot;

    // Rising edge of raw vsync starts a frame; only honoured from IDLE while running
    assign frame_tick = vsync & ~vsync_q;
    assign accept     = (state_q == IDLE) && frame_tick && run;
    // A simultaneous clear wins over the frame accept, so the LFSR must not advance either
    assign lfsr_step  = accept && !clear;
    assign last_slot  = (state_q == SCROLL) && (idx_q == LAST_IDX);

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (system_clock_in),
        .reset_n (system_reset_n_in),
        .step    (lfsr_step),
        .q       (lfsr_q)
    );

    // Burst state register
    always_ff @(posedge system_clock_in) begin
        if (!system_reset_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> 10 SCROLL cycles -> 1 SPAWN cycle -> IDLE; clear aborts to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCROLL;
            SCROLL:  if (idx_q == LAST_IDX) state_d = SPAWN;
            SPAWN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    // Scroll the slot under idx: retire if it would cross the left edge, else move left
    always_comb begin
        cur_word    = obstacles[idx_q];
        cur_pos     = cur_word[POS_MSB:POS_LSB];
        speed_ext   = {{(POS_W - 4){1'b0}}, speed_q};
        scroll_word = cur_word;
        if (cur_word[ACTIVE_BIT]) begin
            if (cur_pos < speed_ext) begin
                scroll_word = '0;
            end else begin
                scroll_word[POS_MSB:POS_LSB] = cur_pos - speed_ext;
            end
        end
    end

    // Lowest-index free slot; scanning high to low lets the lowest match win
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
            if (!obstacles[i][ACTIVE_BIT]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Spawn only when the gap has fully elapsed and a slot is free; otherwise retry next frame
    assign spawn_go   = (state_q == SPAWN) && (gap_cnt == GAP_MAX) && free_found;
    assign spawn_word = make_spawn_word(lfsr_q[4:0], SPAWN_X);

    // Obstacle table: one slot rewritten per SCROLL cycle, one insert in SPAWN
    always_ff @(posedge system_clock_in) begin
        if (!system_reset_n_in) begin
            obstacles <= '0;
        end else if (clear) begin
            obstacles <= '0;
        end else if (state_q == SCROLL) begin
            obstacles[idx_q] <= scroll_word;
        end else if (spawn_go) begin
            obstacles[free_idx] <= spawn_word;
        end
    end

    // Burst bookkeeping: slot index, latched speed, spawn gap counter
    always_ff @(posedge system_clock_in) begin
        if (!system_reset_n_in) begin
            idx_q   <= '0;
            speed_q <= '0;
            gap_cnt <= '0;
        end else if (clear) begin
            idx_q   <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                idx_q   <= '0;
                speed_q <= speed;
            end else if (state_q == SCROLL) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (last_slot) begin
                if (gap_cnt < GAP_MAX) begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
            end else if (spawn_go) begin
                gap_cnt <= '0;
            end
        end
    end

    // Registered status outputs and the vsync edge detector
    always_ff @(posedge system_clock_in) begin
        if (!system_reset_n_in) begin
            vsync_q     <= 1'b0;
            busy        <= 1'b0;
            spawn_pulse <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            busy        <= (state_d != IDLE);
            spawn_pulse <= spawn_go && !clear;
        end
    end

endmodule
